// File: rtl/multicycle_controller.sv
// multicycle_controller
// Control unit for a multicycle RV32I core. A registered main FSM walks each
// instruction through fetch/decode/execute/memory/writeback; the immediate
// format select and the ALU operation are decoded combinationally from the
// FSM state and the instruction fields held in the instruction register.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   op, funct3, funct7b5  instruction fields (stable for the whole instruction)
//   zero                  ALU zero flag, gates the branch PC update
//   ImmSrc                immediate format select (00 I, 01 S, 10 B, 11 J)
//   ALUSrcA, ALUSrcB      ALU operand selects
//   ResultSrc, AdrSrc     result mux and memory address selects
//   ALUControl            ALU operation
//   IRWrite, PCWrite,
//   RegWrite, MemWrite    write strobes
//   state                 current FSM state (debug)
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic [2:0] ALUControl,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] state
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       branch;
  logic       pc_update;

  // Async reset puts the FSM in FETCH immediately, so the Moore outputs show
  // the FETCH values for as long as reset_n is held low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= state_t'(RESET_STATE);
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;  // unknown opcode: dropped, no writes
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;      // codes 11-15 recover to FETCH
    endcase
  end

  // Moore outputs: everything defaults to zero, each state raises its own set.
  always_comb begin
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    alu_op    = 2'b00;
    branch    = 1'b0;
    pc_update = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA = 2'b10;
        branch  = 1'b1;
        alu_op  = 2'b01;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  // The branch term is the only path from the zero flag to an output.
  assign PCWrite = pc_update | (branch & zero);

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // op[5] separates R-type (sub when funct7b5) from I-type (always addi).
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  assign state = state_q;

endmodule
